// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge and its APB register completer.
//   APB_PDATA_SIZE  : APB data/address width
//   APB_ID_VALUE    : identification word returned by completer register 0
//   apb_cmp_state_e : completer FSM states
//   apb_strb_merge  : byte-lane write merge (strb[b]=1 takes wdata byte b)
package ahb_apb_bridge_pkg;

  localparam int APB_PDATA_SIZE = 32;
  localparam int APB_STRB_SIZE  = APB_PDATA_SIZE / 8;

  localparam logic [APB_PDATA_SIZE-1:0] APB_ID_VALUE = 32'hA2B0_0001;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_cmp_state_e;

  function automatic logic [APB_PDATA_SIZE-1:0] apb_strb_merge(
    input logic [APB_PDATA_SIZE-1:0] old_val,
    input logic [APB_PDATA_SIZE-1:0] wdata,
    input logic [APB_STRB_SIZE-1:0]  strb
  );
    logic [APB_PDATA_SIZE-1:0] m;
    m = old_val;
    for (int b = 0; b < APB_STRB_SIZE; b++)
      if (strb[b]) m[b*8 +: 8] = wdata[b*8 +: 8];
    return m;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer.
//   i_clk / i_rst_n : clock, synchronous active-low reset (clears registers 1..N-1)
//   i_we            : commit strobe; i_widx / i_wdata / i_wstrb select target and byte lanes
//   i_ridx          : read index; o_rdata is the combinational read mux (0 if out of range)
//   o_regs          : flattened contents, register i at [i*PDATA_SIZE +: PDATA_SIZE]
// Register 0 is the constant ID word and has no storage.
module apb_reg_bank
  import ahb_apb_bridge_pkg::*;
#(
  parameter int                    PDATA_SIZE = APB_PDATA_SIZE,
  parameter int                    NUM_REGS   = 8,
  parameter logic [PDATA_SIZE-1:0] ID_VALUE   = APB_ID_VALUE
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_we,
  input  logic [$clog2(NUM_REGS)-1:0]    i_widx,
  input  logic [PDATA_SIZE-1:0]          i_wdata,
  input  logic [PDATA_SIZE/8-1:0]        i_wstrb,
  input  logic [$clog2(NUM_REGS)-1:0]    i_ridx,
  output logic [PDATA_SIZE-1:0]          o_rdata,
  output logic [NUM_REGS*PDATA_SIZE-1:0] o_regs
);

  localparam int IW = $clog2(NUM_REGS);

  assign o_regs[0 +: PDATA_SIZE] = ID_VALUE;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic [PDATA_SIZE-1:0] r_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)
        r_q <= '0;
      else if (i_we && (i_widx == IW'(i)))
        r_q <= apb_strb_merge(r_q, i_wdata, i_wstrb);
    end
    assign o_regs[i*PDATA_SIZE +: PDATA_SIZE] = r_q;
  end

  // Indices past NUM_REGS (non power-of-two banks) read as zero.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i_ridx == IW'(i)) o_rdata = o_regs[i*PDATA_SIZE +: PDATA_SIZE];
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer answering the bridge's APB port with a small register bank.
//   PCLK, PRESETn             : clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE/PPROT : APB control (only PPROT[0] is used)
//   PADDR/PWDATA/PSTRB        : address, write data, write byte lanes
//   PRDATA/PREADY/PSLVERR     : registered response, valid for one cycle
//   regs_o                    : flattened register contents
// WAIT_CYCLES wait states are inserted in every access phase. Address, direction
// and error are captured at the setup edge; writes commit on the completion edge.
module apb_reg_completer
  import ahb_apb_bridge_pkg::*;
#(
  parameter int                    PDATA_SIZE  = APB_PDATA_SIZE,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [PDATA_SIZE-1:0] ID_VALUE    = APB_ID_VALUE
)(
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [2:0]                     PPROT,
  input  logic [PDATA_SIZE/8-1:0]        PSTRB,
  input  logic [PDATA_SIZE-1:0]          PADDR,
  input  logic [PDATA_SIZE-1:0]          PWDATA,
  output logic [PDATA_SIZE-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*PDATA_SIZE-1:0] regs_o
);

  localparam int IW = $clog2(NUM_REGS);

  apb_cmp_state_e        r_state;
  logic [3:0]            r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_err;
  logic                  r_write;
  logic [PDATA_SIZE-1:0] r_rdq;
  logic [PDATA_SIZE-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic [IW-1:0]         w_idx;
  logic                  w_oob;
  logic                  w_err;
  logic [PDATA_SIZE-1:0] w_bank_rdata;
  logic [PDATA_SIZE-1:0] w_rd;
  logic                  w_setup;
  logic                  w_complete;
  logic                  w_commit;
  logic                  w_unused;

  assign w_unused = &{1'b0, PPROT[2:1]};

  // Decode of the live bus; only meaningful on the setup edge.
  assign w_idx   = PADDR[IW+1:2];
  assign w_oob   = (PADDR >> 2) >= PDATA_SIZE'(NUM_REGS);
  assign w_err   = (PADDR[1:0] != 2'b00) | w_oob |
                   (PWRITE & ((w_idx == '0) | ~PPROT[0]));
  // Writes and errored reads return zero, so the captured word is the final PRDATA.
  assign w_rd    = (PWRITE | w_err) ? '0 : w_bank_rdata;
  assign w_setup = PSEL & ~PENABLE;

  assign w_complete = (r_state == ACCESS) & PSEL & PENABLE & r_pready;
  assign w_commit   = w_complete & r_write & ~r_err;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_rdq     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // PENABLE without a preceding setup falls through here untouched.
          if (w_setup) begin
            r_state <= ACCESS;
            r_idx   <= w_idx;
            r_err   <= w_err;
            r_write <= PWRITE;
            r_rdq   <= w_rd;
            r_cnt   <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rd;
            end
          end
        end
        ACCESS: begin
          if (!PSEL || w_complete) begin
            // Abort or completion: response lasts exactly one cycle.
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
          end else if (r_cnt != '0) begin
            // Counter at 1 means the coming cycle is the last access cycle.
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= r_err;
              r_prdata  <= r_rdq;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

  apb_reg_bank #(
    .PDATA_SIZE (PDATA_SIZE),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_we    (w_commit),
    .i_widx  (r_idx),
    .i_wdata (PWDATA),
    .i_wstrb (PSTRB),
    .i_ridx  (w_idx),
    .o_rdata (w_bank_rdata),
    .o_regs  (regs_o)
  );

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: three instances (0, 3 and 2 wait states) share one
// APB bus, with PSEL steered to the instance under test.
module tb_apb_reg_completer;

  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA2B0_0001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] paddr = '0, pwdata = '0;
  int          cur = 0;

  logic [31:0]      prdata_d  [3];
  logic             pready_d  [3];
  logic             pslverr_d [3];
  logic [NR*32-1:0] regs_d    [3];
  int               wexp      [3] = '{0, 3, 2};

  apb_reg_completer #(.PDATA_SIZE(32), .NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_w0 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel && cur == 0), .PENABLE(penable), .PWRITE(pwrite),
    .PPROT(pprot), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_d[0]), .PREADY(pready_d[0]), .PSLVERR(pslverr_d[0]), .regs_o(regs_d[0]));

  apb_reg_completer #(.PDATA_SIZE(32), .NUM_REGS(NR), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_w3 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel && cur == 1), .PENABLE(penable), .PWRITE(pwrite),
    .PPROT(pprot), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_d[1]), .PREADY(pready_d[1]), .PSLVERR(pslverr_d[1]), .regs_o(regs_d[1]));

  apb_reg_completer #(.PDATA_SIZE(32), .NUM_REGS(NR), .WAIT_CYCLES(2), .ID_VALUE(ID)) u_w2 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel && cur == 2), .PENABLE(penable), .PWRITE(pwrite),
    .PPROT(pprot), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_d[2]), .PREADY(pready_d[2]), .PSLVERR(pslverr_d[2]), .regs_o(regs_d[2]));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain register array per instance.
  logic [31:0] mdl [3][NR];

  task automatic m_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NR; i++) mdl[d][i] = '0;
  endtask

  function automatic bit m_err(bit wr, logic [31:0] a, logic [2:0] pr);
    return (a % 4 != 0) || (a / 4 >= NR) || (wr && (a / 4 == 0 || !pr[0]));
  endfunction

  function automatic logic [31:0] m_read(int d, logic [31:0] a);
    int idx = int'(a / 4);
    return (idx == 0) ? ID : mdl[d][idx];
  endfunction

  task automatic m_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] mask = '0;
    int idx = int'(a / 4);
    for (int b = 0; b < 4; b++) if (st[b]) mask = mask | (32'hFF << (8 * b));
    mdl[d][idx] = (mdl[d][idx] & ~mask) | (wd & mask);
  endtask

  task automatic chk_regs(input string nm, input int d);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s reg%0d", nm, i), regs_d[d][i*32 +: 32], (i == 0) ? ID : mdl[d][i]);
  endtask

  // One APB transfer, entered just after a rising edge. keep=1 leaves PSEL up
  // so the next call issues its setup in the cycle right after completion.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input bit keep,
                      output logic [31:0] rd, output logic er, output int waits);
    bit done = 1'b0;
    cur = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    @(negedge clk);
    chk("PREADY low in setup", 32'(pready_d[d]), 0);
    @(posedge clk); #1 penable = 1'b1;
    waits = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pready_d[d]) begin done = 1'b1; rd = prdata_d[d]; er = pslverr_d[d]; end
      else waits++;
    end
    chk("PREADY seen", 32'(done), 1);
    @(posedge clk); #1;
    if (!keep) begin psel = 1'b0; penable = 1'b0; end
  endtask

  // Transfer checked against the model.
  task automatic run(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [2:0] pr, input bit keep, input string nm);
    logic [31:0] rd; logic er; int w;
    bit e_err = m_err(wr, a, pr);
    logic [31:0] e_rd = (wr || e_err) ? 32'h0 : m_read(d, a);
    xfer(d, wr, a, wd, st, pr, keep, rd, er, w);
    chk({nm, " rdata"}, rd, e_rd);
    chk({nm, " pslverr"}, 32'(er), 32'(e_err));
    chk({nm, " waits"}, w, wexp[d]);
    if (wr && !e_err) m_write(d, a, wd, st);
    chk_regs(nm, d);
  endtask

  // Reset asserted while the wait-2 instance holds PREADY high.
  task automatic reset_mid(input bit wr, input logic [31:0] a, input logic [31:0] wd, input string nm);
    bit seen = 1'b0;
    cur = 2; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pready_d[2]) seen = 1'b1;
    end
    chk({nm, " PREADY before reset"}, 32'(seen), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    m_clear();
    @(negedge clk);
    chk({nm, " PREADY"}, 32'(pready_d[2]), 0);
    chk({nm, " PSLVERR"}, 32'(pslverr_d[2]), 0);
    chk({nm, " PRDATA"}, prdata_d[2], 0);
    chk_regs(nm, 2);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [2:0]  pr;
    logic [31:0] erd;
    bit          eer;
  } vec_t;

  vec_t tv [18];

  initial begin
    logic [31:0] rd; logic er; int w; bit seen;

    tv[0]  = '{0, 32'h00, 32'h0,         4'h0, 3'b001, 32'hA2B0_0001, 0};
    tv[1]  = '{1, 32'h04, 32'hDEAD_BEEF, 4'h5, 3'b001, 32'h0,         0};
    tv[2]  = '{0, 32'h04, 32'h0,         4'h0, 3'b001, 32'h00AD_00EF, 0};
    tv[3]  = '{1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0,         1};
    tv[4]  = '{1, 32'h04, 32'h1111_1111, 4'hF, 3'b000, 32'h0,         1};
    tv[5]  = '{0, 32'h06, 32'h0,         4'h0, 3'b001, 32'h0,         1};
    tv[6]  = '{0, 32'h20, 32'h0,         4'h0, 3'b001, 32'h0,         1};
    tv[7]  = '{0, 32'h04, 32'h0,         4'h0, 3'b001, 32'h00AD_00EF, 0};
    tv[8]  = '{1, 32'h1C, 32'h1234_5678, 4'hF, 3'b001, 32'h0,         0};
    tv[9]  = '{0, 32'h1C, 32'h0,         4'h0, 3'b001, 32'h1234_5678, 0};
    tv[10] = '{0, 32'h00, 32'h0,         4'h0, 3'b000, 32'hA2B0_0001, 0};
    tv[11] = '{1, 32'h08, 32'hAAAA_AAAA, 4'h0, 3'b001, 32'h0,         0};
    tv[12] = '{0, 32'h08, 32'h0,         4'h0, 3'b001, 32'h0,         0};
    tv[13] = '{1, 32'h04, 32'h0000_5500, 4'h2, 3'b001, 32'h0,         0};
    tv[14] = '{0, 32'h04, 32'h0,         4'h0, 3'b001, 32'h00AD_55EF, 0};
    tv[15] = '{1, 32'h02, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0,         1};
    tv[16] = '{0, 32'h04, 32'h0,         4'h0, 3'b111, 32'h00AD_55EF, 0};
    tv[17] = '{0, 32'h24, 32'h0,         4'h0, 3'b001, 32'h0,         1};

    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset PREADY d%0d", d), 32'(pready_d[d]), 0);
      chk($sformatf("reset PSLVERR d%0d", d), 32'(pslverr_d[d]), 0);
      chk($sformatf("reset PRDATA d%0d", d), prdata_d[d], 0);
      chk_regs($sformatf("reset d%0d", d), d);
    end
    @(posedge clk); #1 rstn = 1'b1;

    // Directed table on the zero-wait instance.
    for (int i = 0; i < 18; i++) begin
      xfer(0, tv[i].wr, tv[i].a, tv[i].wd, tv[i].st, tv[i].pr, 1'b0, rd, er, w);
      chk($sformatf("vec%0d rdata", i), rd, tv[i].erd);
      chk($sformatf("vec%0d pslverr", i), 32'(er), 32'(tv[i].eer));
      chk($sformatf("vec%0d waits", i), w, 0);
      if (tv[i].wr && !tv[i].eer) m_write(0, tv[i].a, tv[i].wd, tv[i].st);
    end
    chk_regs("after table", 0);

    // PENABLE without a setup must be ignored.
    cur = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001;
    repeat (2) begin
      @(negedge clk);
      chk("stray PENABLE PREADY", 32'(pready_d[0]), 0);
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    chk_regs("stray PENABLE", 0);

    // Three wait states, then a back-to-back write and read-back.
    run(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, 1'b1, "w3 read");
    run(1, 1'b1, 32'h8, 32'h55AA_1234, 4'hF, 3'b001, 1'b1, "w3 b2b write");
    run(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, 1'b0, "w3 readback");

    for (int i = 0; i < 40; i++) begin
      int r = int'($urandom_range(0, 11));
      logic [31:0] a = 32'(r * 4) + ((r >= 10) ? 32'($urandom_range(1, 3)) : 32'h0);
      run(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)), (i != 39) && 1'($urandom_range(0, 1)), $sformatf("rnd0 #%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      int r = int'($urandom_range(0, 9));
      run(1, 1'($urandom_range(0, 1)), 32'(r * 4), $urandom, 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)), (i != 14) && 1'($urandom_range(0, 1)), $sformatf("rnd3 #%0d", i));
    end

    // Abort: PSEL dropped after one access cycle of a write.
    cur = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
    pwdata = 32'h9999_9999; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready_d[2]) seen = 1'b1;
    end
    chk("abort PREADY never high", 32'(seen), 0);
    @(posedge clk); #1;
    chk_regs("abort", 2);
    run(2, 1'b0, 32'hC, 32'h0, 4'h0, 3'b001, 1'b0, "after abort read");

    // Reset during an in-flight write, then during a read of a live register.
    run(2, 1'b1, 32'h4, 32'h1111_1111, 4'hF, 3'b001, 1'b0, "w2 setup write");
    reset_mid(1'b1, 32'h8, 32'hCAFE_F00D, "reset mid write");
    run(2, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, 1'b0, "post reset read8");
    run(2, 1'b1, 32'h4, 32'h2222_2222, 4'hF, 3'b001, 1'b0, "w2 rewrite");
    reset_mid(1'b0, 32'h4, 32'h0, "reset mid read");
    run(2, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, 1'b0, "post reset read4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
